// File: rtl/io_map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_map_pkg                                                           |
// | Holds the MMIO register offsets, the access-size codes and the       |
// | byte-lane read/write helpers.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package io_map_pkg;

  localparam logic [9:0] OFF_LED       = 10'h000;
  localparam logic [9:0] OFF_SW        = 10'h010;
  localparam logic [9:0] OFF_BTN_LEVEL = 10'h020;
  localparam logic [9:0] OFF_BTN_EVENT = 10'h024;
  localparam logic [9:0] OFF_SEG       = 10'h030;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_UBYTE = 2'b10;

  function automatic logic [31:0] read_format(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    case (size)
      SZ_BYTE:  r = {{24{b[7]}}, b};
      SZ_UBYTE: r = {24'h000000, b};
      default:  r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] write_merge(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old;
    if (size == SZ_BYTE || size == SZ_UBYTE)
      r[{lane, 3'b000} +: 8] = data[7:0];
    else
      r = data;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_debounce                                                          |
// | One push button: 2-flop synchroniser plus, with IO_DEBOUNCE_EN, a    |
// | stable-count filter. Without the macro it is the bare synchroniser.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module io_debounce #(
  parameter int unsigned CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam bit FILTER = (CYCLES > 0);
`else
  localparam bit FILTER = 1'b0 && (CYCLES > 0);
`endif

  if (FILTER) begin : g_filter
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    logic [CW-1:0] count;
    logic          state;

    // Level flips on the CYCLES-th consecutive edge that sees a difference.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= '0;
        state <= 1'b0;
      end else if (sync == state) begin
        count <= '0;
      end else if (count == CW'(CYCLES - 1)) begin
        count <= '0;
        state <= ~state;
      end else begin
        count <= count + CW'(1);
      end
    end

    assign level = state;
  end else begin : g_bare
    assign level = sync;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_responder                                                       |
// | MMIO register block for LEDs, switches, buttons and 7-segment data;  |
// | button filtering is selected by IO_DEBOUNCE_EN.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mmio_responder
  import io_map_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned LED_WIDTH       = 16,
  parameter int unsigned BTN_WIDTH       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 ioread_i,
  input  logic                 iowrite_i,
  input  logic [9:0]           addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [1:0]           byte_or_word_i,
  output logic [31:0]          rdata_o,
  input  logic [SW_WIDTH-1:0]  switch_i,
  input  logic [BTN_WIDTH-1:0] button_i,
  output logic [LED_WIDTH-1:0] led_o,
  output logic [31:0]          seg_data_o
);

  logic [SW_WIDTH-1:0]  sw_meta;
  logic [SW_WIDTH-1:0]  sw_sync;
  logic [BTN_WIDTH-1:0] btn_level;
  logic [BTN_WIDTH-1:0] btn_level_q;
  logic [BTN_WIDTH-1:0] btn_event;
  logic [BTN_WIDTH-1:0] btn_rise;
  logic [9:0]           word_off;
  logic [1:0]           lane;
  logic [31:0]          rd_word;
  logic                 event_clear;

  assign word_off    = {addr_i[9:2], 2'b00};
  assign lane        = addr_i[1:0];
  assign event_clear = ioread_i && (word_off == OFF_BTN_EVENT);
  assign btn_rise    = btn_level & ~btn_level_q;

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    io_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .raw   (button_i[i]),
      .level (btn_level[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_i;
      sw_sync <= sw_meta;
    end
  end

  // Pre-write view of every register, so a same-cycle write is not seen.
  always_comb begin
    rd_word = '0;
    case (word_off)
      OFF_LED:       rd_word = 32'(led_o);
      OFF_SW:        rd_word = 32'(sw_sync);
      OFF_BTN_LEVEL: rd_word = 32'(btn_level);
      OFF_BTN_EVENT: rd_word = 32'(btn_event);
      OFF_SEG:       rd_word = seg_data_o;
      default:       rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_level_q <= '0;
      btn_event   <= '0;
    end else begin
      btn_level_q <= btn_level;
      // A rise coinciding with the clearing read survives the clear.
      btn_event   <= (event_clear ? '0 : btn_event) | btn_rise;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      led_o      <= '0;
      seg_data_o <= '0;
      rdata_o    <= '0;
    end else begin
      if (iowrite_i && word_off == OFF_LED)
        led_o <= LED_WIDTH'(write_merge(32'(led_o), wdata_i, byte_or_word_i, lane));
      if (iowrite_i && word_off == OFF_SEG)
        seg_data_o <= write_merge(seg_data_o, wdata_i, byte_or_word_i, lane);
      if (ioread_i)
        rdata_o <= read_format(rd_word, byte_or_word_i, lane);
    end
  end

endmodule
`default_nettype wire
